// File: rtl/pc_branch_sequencer_if.sv
// Fetch-side bus of the PC sequencer: redirect requests from the resolving
// control-transfer instruction in, fetch address and status out.
interface pc_branch_sequencer_if;
   logic        stall;
   logic [31:0] br_pc4;
   logic [31:0] offset_shifted;
   logic        branch_en;
   logic        branch_ne;
   logic        alu_zero;
   logic        jump_en;
   logic [25:0] jump_index;
   logic        jr_en;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        flush;
   logic        in_slot;
   logic        err;

   modport master (
      output stall, br_pc4, offset_shifted, branch_en, branch_ne, alu_zero,
             jump_en, jump_index, jr_en, jr_target,
      input  pc, pc_plus4, flush, in_slot, err
   );

   modport slave (
      input  stall, br_pc4, offset_shifted, branch_en, branch_ne, alu_zero,
             jump_en, jump_index, jr_en, jr_target,
      output pc, pc_plus4, flush, in_slot, err
   );
endinterface

// File: rtl/pc_branch_sequencer.sv
// Program counter and next-PC selection for the MIPS fetch stage, with an
// optional single branch delay slot. RESET_PC must be word-aligned.
module pc_branch_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          DELAY_SLOT = 1
) (
   input logic                   clk,
   input logic                   reset,
   pc_branch_sequencer_if.slave  bus
);

   typedef enum logic {SEQ, SLOT} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pending;
   logic        r_flush;
   logic        r_inSlot;
   logic        r_err;

   logic        w_takeBr;
   logic        w_redirect;
   logic        w_jrMisaligned;
   logic [31:0] w_target;
   logic [31:0] w_pcPlus4;

   // Redirect decode; target priority is jr over jump over branch.
   always_comb begin
      w_takeBr       = bus.branch_en & (bus.alu_zero ^ bus.branch_ne);
      w_redirect     = bus.jr_en | bus.jump_en | w_takeBr;
      w_jrMisaligned = bus.jr_en & (bus.jr_target[1:0] != 2'b00);
      w_pcPlus4      = r_pc + 32'd4;
      if (bus.jr_en) begin
         w_target = {bus.jr_target[31:2], 2'b00};
      end else if (bus.jump_en) begin
         w_target = {bus.br_pc4[31:28], bus.jump_index, 2'b00};
      end else begin
         w_target = bus.br_pc4 + bus.offset_shifted;
      end
   end

   // Sequencer: a stall freezes everything except the flush pulse, and
   // a redirect seen while the delay-slot fetch is outstanding is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= SEQ;
         r_pc      <= RESET_PC;
         r_pending <= 32'd0;
         r_flush   <= 1'b0;
         r_inSlot  <= 1'b0;
         r_err     <= 1'b0;
      end else if (bus.stall) begin
         r_flush <= 1'b0;
      end else begin
         case (r_state)
            SEQ: begin
               if (w_redirect) begin
                  if (w_jrMisaligned) begin
                     r_err <= 1'b1;
                  end
                  if (DELAY_SLOT != 0) begin
                     r_pending <= w_target;
                     r_pc      <= w_pcPlus4;
                     r_inSlot  <= 1'b1;
                     r_flush   <= 1'b0;
                     r_state   <= SLOT;
                  end else begin
                     r_pc    <= w_target;
                     r_flush <= 1'b1;
                  end
               end else begin
                  r_pc    <= w_pcPlus4;
                  r_flush <= 1'b0;
               end
            end
            SLOT: begin
               r_pc     <= r_pending;
               r_inSlot <= 1'b0;
               r_flush  <= 1'b0;
               r_state  <= SEQ;
               if (w_redirect) begin
                  r_err <= 1'b1;
               end
            end
            default: begin
               r_state <= SEQ;
            end
         endcase
      end
   end

   assign bus.pc       = r_pc;
   assign bus.pc_plus4 = w_pcPlus4;
   assign bus.flush    = r_flush;
   assign bus.in_slot  = r_inSlot;
   assign bus.err      = r_err;

endmodule
